line_mem_responder: RTL and testbench

//  Main-memory responder on the far side of the I-/D-cache refill/writeback port in the pipelined MIPS.

---
 rtl/line_mem_responder.sv | 153 +++++++++++++++
 tb/tb_line_mem_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// line_mem_responder: main-memory responder for cache line refills and writebacks.
// Accepts one line request at a time. A read streams the line out as WORDS_PER_LINE
// 32-bit beats, starting LATENCY edges after accept. A write collects WORDS_PER_LINE
// beats, then pulses wdone_o LATENCY edges after the last beat.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge) and async active-low reset
//   req_valid_i/req_ready_o  request handshake; req_write_i selects writeback vs refill
//   req_addr_i               byte address of the line (in-line offset ignored)
//   wvalid_i, wdata_i        write beats, consumed only while collecting a line
//   rvalid_o, rdata_o        registered read beats; rlast_o marks the final beat
//   wdone_o                  one-cycle pulse when a line write completes
//   busy_o                   request in progress (inverse of req_ready_o)
module line_mem_responder #(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned LATENCY        = 8,
  parameter int unsigned DEPTH_WORDS    = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  output logic        req_ready_o,
  input  logic        wvalid_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        rlast_o,
  output logic        wdone_o,
  output logic        busy_o
);

  localparam int unsigned OffW  = $clog2(WORDS_PER_LINE);
  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);
  localparam int unsigned LineW = AddrW - OffW;
  localparam int unsigned CntW  = $clog2(LATENCY + 1);

  localparam logic [OffW-1:0] LastBeat = OffW'(WORDS_PER_LINE - 1);
  localparam logic [CntW-1:0] LatLast  = CntW'(LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle, StRWait, StRBurst, StWData, StWWait, StWDone
  } state_e;

  state_e            state_q, state_d;
  logic [LineW-1:0]  line_q;
  logic [OffW-1:0]   beat_q;
  logic [CntW-1:0]   lat_cnt_q;
  logic              rvalid_q, rlast_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              lat_done;
  logic              rd_fire;
  logic [AddrW-1:0]  mem_addr;

  // Upper address bits wrap (modulo depth); byte and in-line offsets are dropped.
  logic unused_addr;
  assign unused_addr = ^{req_addr_i[31:AddrW+2], req_addr_i[OffW+1:0]};

  assign lat_done = (lat_cnt_q == LatLast);
  assign mem_addr = {line_q, beat_q};
  // Load a beat on the edge leaving the wait, and on every burst edge until rlast.
  assign rd_fire  = ((state_q == StRWait) && lat_done) || ((state_q == StRBurst) && !rlast_q);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid_i) state_d = req_write_i ? StWData : StRWait;
      StRWait:  if (lat_done) state_d = StRBurst;
      StRBurst: if (rlast_q) state_d = StIdle;
      StWData:  if (wvalid_i && (beat_q == LastBeat)) state_d = StWWait;
      StWWait:  if (lat_done) state_d = StWDone;
      StWDone:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req_ready_o = 1'b0;
    wdone_o     = 1'b0;
    req_ready_o = (state_q == StIdle);
    wdone_o     = (state_q == StWDone);
  end

  assign busy_o   = ~req_ready_o;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rlast_o  = rlast_q;

  // Line base, beat and latency counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q    <= '0;
      beat_q    <= '0;
      lat_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            line_q    <= req_addr_i[AddrW+1:OffW+2];
            beat_q    <= '0;
            lat_cnt_q <= '0;
          end
        end
        StRWait: begin
          if (lat_done) begin
            lat_cnt_q <= '0;
            beat_q    <= beat_q + OffW'(1);
          end else begin
            lat_cnt_q <= lat_cnt_q + CntW'(1);
          end
        end
        StWWait:  lat_cnt_q <= lat_done ? '0 : lat_cnt_q + CntW'(1);
        StRBurst: if (!rlast_q) beat_q <= beat_q + OffW'(1);
        StWData:  if (wvalid_i) beat_q <= beat_q + OffW'(1);
        default: ;
      endcase
    end
  end

  // Registered read beats
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
    end else if (rd_fire) begin
      rvalid_q <= 1'b1;
      rlast_q  <= (state_q == StRBurst) && (beat_q == LastBeat);
      rdata_q  <= mem_q[mem_addr];
    end else begin
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
    end
  end

  // Storage array: never reset, so a partial line survives a mid-write reset.
  always_ff @(posedge clk_i) begin
    if ((state_q == StWData) && wvalid_i) mem_q[mem_addr] <= wdata_i;
  end

endmodule

// File: tb/tb_line_mem_responder.sv
module tb_line_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        wvalid;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rlast;
  logic        wdone;
  logic        busy;

  int checks = 0;
  int errors = 0;

  line_mem_responder #(
    .WORDS_PER_LINE(4),
    .LATENCY       (8),
    .DEPTH_WORDS   (1024)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_write_i(req_write),
    .req_addr_i (req_addr),
    .req_ready_o(req_ready),
    .wvalid_i   (wvalid),
    .wdata_i    (wdata),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .rlast_o    (rlast),
    .wdone_o    (wdone),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read one line; entered and left at a negedge. Cycle j is the cycle starting
  // j edges after the accepting edge; beats are expected in cycles 8..11.
  task automatic do_read(input string name, input logic [31:0] addr,
                         input logic [3:0][31:0] exp, input bit stray, input bit keep,
                         input logic nxt_write, input logic [31:0] nxt_addr);
    logic [4:0] st;
    logic [4:0] st_exp;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s entry req_ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    @(negedge clk);
    if (keep) begin
      req_write = nxt_write;
      req_addr  = nxt_addr;
    end else begin
      req_valid = 1'b0;
    end
    for (int j = 0; j <= 12; j++) begin
      wvalid = stray && (j < 12);
      wdata  = 32'hDEAD_0000 | 32'(j);
      st     = {busy, req_ready, rvalid, rlast, wdone};
      st_exp = {(j != 12), (j == 12), (j >= 8 && j <= 11), (j == 11), 1'b0};
      checks++;
      if (st !== st_exp) begin
        errors++;
        $display("FAIL %s status cyc %0d: got busy/ready/rvalid/rlast/wdone=%b want %b",
                 name, j, st, st_exp);
      end
      if (j >= 8 && j <= 11) begin
        checks++;
        if (rdata !== exp[j-8]) begin
          errors++;
          $display("FAIL %s rdata beat %0d: got %h want %h", name, j - 8, rdata, exp[j-8]);
        end
      end
      if (j < 12) @(negedge clk);
    end
    wvalid = 1'b0;
  endtask

  // Write one line with gaps[i] idle cycles before beat i; wdone expected 8 cycles
  // after the cycle that began with the last-beat edge.
  task automatic do_write(input string name, input logic [31:0] addr,
                          input logic [3:0][31:0] d, input logic [3:0][1:0] gaps,
                          input bit keep, input logic nxt_write, input logic [31:0] nxt_addr);
    logic [4:0] st;
    logic [4:0] st_exp;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s entry req_ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    if (keep) begin
      req_write = nxt_write;
      req_addr  = nxt_addr;
    end else begin
      req_valid = 1'b0;
    end
    st = {busy, req_ready, rvalid, rlast, wdone};
    checks++;
    if (st !== 5'b10000) begin
      errors++;
      $display("FAIL %s accepted status: got %b want 10000", name, st);
    end
    for (int i = 0; i < 4; i++) begin
      repeat (int'(gaps[i])) begin
        wvalid = 1'b0;
        @(negedge clk);
      end
      wvalid = 1'b1;
      wdata  = d[i];
      @(negedge clk);
    end
    wvalid = 1'b0;
    for (int n = 0; n <= 9; n++) begin
      st     = {busy, req_ready, rvalid, rlast, wdone};
      st_exp = {(n != 9), (n == 9), 1'b0, 1'b0, (n == 8)};
      checks++;
      if (st !== st_exp) begin
        errors++;
        $display("FAIL %s wdone cyc %0d: got busy/ready/rvalid/rlast/wdone=%b want %b",
                 name, n, st, st_exp);
      end
      if (n < 9) @(negedge clk);
    end
  endtask

  localparam logic [3:0][31:0] Line40 = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [3:0][31:0] Line80 = {32'hA0A0_0004, 32'hA0A0_0003,
                                         32'hA0A0_0002, 32'hA0A0_0001};
  localparam logic [3:0][31:0] LineC0 = {32'h5555_0003, 32'h5555_0002,
                                         32'h5555_0001, 32'h5555_0000};

  task automatic test_reset();
    logic [4:0] st;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    wvalid    = 1'b0;
    wdata     = '0;
    @(negedge clk);
    st = {busy, req_ready, rvalid, rlast, wdone};
    checks++;
    if (st !== 5'b01000) begin
      errors++;
      $display("FAIL reset status: got %b want 01000", st);
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset rdata: got %h want 00000000", rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    st = {busy, req_ready, rvalid, rlast, wdone};
    checks++;
    if (st !== 5'b01000) begin
      errors++;
      $display("FAIL post-reset idle status: got %b want 01000", st);
    end
  endtask

  task automatic test_write_read();
    do_write("wr40", 32'h40, Line40, '0, 1'b0, 1'b0, '0);
    do_read("rd40", 32'h40, Line40, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_addressing();
    // Stray wvalid during this read must not touch the 0x40 line.
    do_read("rd4c", 32'h4C, Line40, 1'b1, 1'b0, 1'b0, '0);
    do_read("rd1040", 32'h1040, Line40, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_write_gaps();
    do_write("wr80", 32'h80, Line80, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      wvalid = 1'b1;
      wdata  = 32'hBAD0_0000 | 32'(i);
      @(negedge clk);
    end
    wvalid = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stray idle req_ready: got %b want 1", req_ready);
    end
    do_read("rd80", 32'h80, Line80, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    do_read("b2b_rd80", 32'h80, Line80, 1'b0, 1'b1, 1'b1, 32'hC0);
    do_write("b2b_wrc0", 32'hC0, LineC0, '0, 1'b1, 1'b0, 32'hC0);
    do_read("b2b_rdc0", 32'hC0, LineC0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_mid_read();
    logic [4:0] st;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if ({rvalid, rdata} !== {1'b1, 32'h22}) begin
      errors++;
      $display("FAIL midreset beat1: got rvalid=%b rdata=%h want 1 00000022", rvalid, rdata);
    end
    #1 rst_n = 1'b0;
    #1;
    st = {busy, req_ready, rvalid, rlast, wdone};
    checks++;
    if (st !== 5'b01000) begin
      errors++;
      $display("FAIL async reset status: got %b want 01000", st);
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL async reset rdata: got %h want 00000000", rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL after reset req_ready: got %b want 1", req_ready);
    end
    do_read("rd40_after_reset", 32'h40, Line40, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_addressing();
    test_write_gaps();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
